// File: rtl/pipeline_pkg.sv
// Shared definitions for the inter-stage pipeline registers: default widths,
// the NOP encoding shown on empty stages and the control-bit layout.
package pipeline_pkg;

    localparam int          CTRL_WIDTH_DEFAULT = 4;
    localparam logic [31:0] NOP_INSTR_DEFAULT  = 32'h0000_0000;

    // Position of each control bit inside the ctrl field
    localparam int CTRL_REG_EN  = 0;
    localparam int CTRL_MUX_SEL = 1;
    localparam int CTRL_MEM_EN  = 2;
    localparam int CTRL_ALU_EN  = 3;

    // Where the main entry takes its next contents from on a clock edge
    typedef enum logic [1:0] {
        MAIN_HOLD,
        MAIN_FROM_SKID,
        MAIN_FROM_IN,
        MAIN_EMPTY
    } main_sel_e;

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus its {ctrl, pc, instr} payload.
// clear wins over load; the payload only changes when an entry is loaded,
// so an emptied slot keeps its last contents.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 68
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    // Valid flag: cleared by reset or clear, set whenever an entry is loaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end
    end

    // Payload register: captures d only on a real load, never on a clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load && !clear) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake. A main entry
// drives the outputs and a skid entry catches the one extra transfer that
// arrives while a stall is propagating, so in_ready comes straight from a
// flop and never depends combinationally on out_ready.
module pipeline_stage_reg
    import pipeline_pkg::*;
#(
    parameter int                     CTRL_WIDTH  = CTRL_WIDTH_DEFAULT,
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = INSTR_WIDTH'(NOP_INSTR_DEFAULT),
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_WIDTH-1:0]  in_ctrl,
    input  logic [PC_WIDTH-1:0]    in_pc,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_WIDTH-1:0]  out_ctrl,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [CNT_WIDTH-1:0]   bubble_cnt
);

    localparam int                   PAYLOAD_WIDTH = CTRL_WIDTH + PC_WIDTH + INSTR_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX       = '1;

    logic                     acc;
    logic                     emit;
    logic                     m_valid;
    logic                     s_valid;
    logic                     m_load;
    logic                     m_clear;
    logic                     s_load;
    logic                     s_clear;
    main_sel_e                m_sel;
    logic [PAYLOAD_WIDTH-1:0] in_payload;
    logic [PAYLOAD_WIDTH-1:0] m_d;
    logic [PAYLOAD_WIDTH-1:0] m_q;
    logic [PAYLOAD_WIDTH-1:0] s_q;

    assign in_payload = {in_ctrl, in_pc, in_instr};

    // s_valid is a flop, so in_ready is registered; it resets to 1 with the skid
    assign in_ready = ~s_valid;
    assign acc      = in_valid & in_ready;
    assign emit     = m_valid & out_ready;

    // Decide how main and skid move this edge; flush overrides every transfer
    always_comb begin
        m_sel   = MAIN_HOLD;
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (flush) begin
            m_sel   = MAIN_EMPTY;
            s_clear = 1'b1;
        end else if (!m_valid) begin
            if (acc) begin
                m_sel = MAIN_FROM_IN;
            end
        end else if (emit) begin
            s_clear = 1'b1;
            if (s_valid) begin
                m_sel = MAIN_FROM_SKID;
            end else if (acc) begin
                m_sel = MAIN_FROM_IN;
            end else begin
                m_sel = MAIN_EMPTY;
            end
        end else if (acc) begin
            s_load = 1'b1;
        end
    end

    // Turn the main-entry selection into slot controls and its data source
    always_comb begin
        m_load  = (m_sel == MAIN_FROM_SKID) || (m_sel == MAIN_FROM_IN);
        m_clear = (m_sel == MAIN_EMPTY);
        m_d     = (m_sel == MAIN_FROM_SKID) ? s_q : in_payload;
    end

    pipe_slot #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .q     (m_q),
        .valid (m_valid)
    );

    pipe_slot #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (s_load),
        .clear (s_clear),
        .d     (in_payload),
        .q     (s_q),
        .valid (s_valid)
    );

    // Present the main entry, masking ctrl and instr whenever it is empty
    always_comb begin
        out_valid = m_valid;
        out_pc    = m_q[INSTR_WIDTH +: PC_WIDTH];
        out_ctrl  = '0;
        out_instr = NOP_INSTR;
        if (m_valid) begin
            out_ctrl  = m_q[INSTR_WIDTH + PC_WIDTH +: CTRL_WIDTH];
            out_instr = m_q[0 +: INSTR_WIDTH];
        end
    end

    // Count cycles where downstream was ready but had nothing to take; saturates, flush leaves it alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (out_ready && !m_valid && (bubble_cnt != CNT_MAX)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed and randomised checks for pipeline_stage_reg: streaming, stall
// with skid, flush, bubble-counter saturation, async reset and a long
// random run compared against a 2-deep in-order queue model.
module tb_pipeline_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_ctrl = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_instr = '0;

    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_ctrl;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [15:0] bubble_cnt;

    logic        d4_in_ready;
    logic        d4_out_valid;
    logic [3:0]  d4_out_ctrl;
    logic [31:0] d4_out_pc;
    logic [31:0] d4_out_instr;
    logic [3:0]  d4_bubble_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_stage_reg dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_pc     (out_pc),
        .out_instr  (out_instr),
        .bubble_cnt (bubble_cnt)
    );

    pipeline_stage_reg #(
        .CNT_WIDTH (4)
    ) dut4 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (d4_in_ready),
        .in_ctrl    (in_ctrl),
        .in_pc      (in_pc),
        .in_instr   (in_instr),
        .out_valid  (d4_out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (d4_out_ctrl),
        .out_pc     (d4_out_pc),
        .out_instr  (d4_out_instr),
        .bubble_cnt (d4_bubble_cnt)
    );

    always #5 clk = ~clk;

    // Payload encoding derived from the pc so every entry is recognisable
    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic logic [3:0] ctrlOf(input logic [31:0] pc);
        return pc[5:2] ^ 4'h9;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Check the visible state of the main instance
    task automatic checkMain(input string tag, input logic v, input logic [31:0] pc, input logic rdy);
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'(v));
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'(rdy));
        if (v) begin
            checkOutput({tag, "_pc"}, out_pc, pc);
            checkOutput({tag, "_instr"}, out_instr, instrOf(pc));
            checkOutput({tag, "_ctrl"}, 32'(out_ctrl), 32'(ctrlOf(pc)));
        end else begin
            checkOutput({tag, "_instr"}, out_instr, NOP);
            checkOutput({tag, "_ctrl"}, 32'(out_ctrl), 32'd0);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and return 1 time unit after the edge
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instrOf(pc);
        in_ctrl   = ctrlOf(pc);
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse placed between clock edges
    task automatic doReset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        #1;
        reset     = 1'b0;
    endtask

    logic [31:0] model_q[$];
    logic [31:0] next_pc;
    logic [31:0] exp_pc;
    logic        rv;
    logic        rr;
    logic        rf;
    logic        m_acc;
    logic        m_emit;

    initial begin
        // Reset state
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_ctrl", 32'(out_ctrl), 32'd0);
        checkOutput("rst_instr", out_instr, NOP);
        checkOutput("rst_pc", out_pc, 32'd0);
        checkOutput("rst_bubble", 32'(bubble_cnt), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // 1: stream of four entries, one cycle latency, one fill bubble
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
        checkMain("t1_e0", 1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h104, 1'b1, 1'b0);
        checkMain("t1_e1", 1'b1, 32'h104, 1'b1);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        checkMain("t1_e2", 1'b1, 32'h108, 1'b1);
        applyStimulus(1'b1, 32'h10C, 1'b1, 1'b0);
        checkMain("t1_e3", 1'b1, 32'h10C, 1'b1);
        checkOutput("t1_bubble", 32'(bubble_cnt), 32'd1);

        // 2: three stall cycles with upstream still pushing
        doReset();
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0);
        checkMain("t2_s0", 1'b1, 32'h100, 1'b1);
        applyStimulus(1'b1, 32'h104, 1'b0, 1'b0);
        checkMain("t2_s1", 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b1, 32'h108, 1'b0, 1'b0);
        checkMain("t2_s2", 1'b1, 32'h100, 1'b0);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        checkMain("t2_r0", 1'b1, 32'h104, 1'b1);
        applyStimulus(1'b1, 32'h108, 1'b1, 1'b0);
        checkMain("t2_r1", 1'b1, 32'h108, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkMain("t2_end", 1'b0, 32'h0, 1'b1);
        checkOutput("t2_bubble", 32'(bubble_cnt), 32'd0);

        // 3: flush with both entries full, then flush eating an accepted entry
        doReset();
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h204, 1'b0, 1'b0);
        checkMain("t3_full", 1'b1, 32'h200, 1'b0);
        applyStimulus(1'b1, 32'h208, 1'b0, 1'b1);
        checkMain("t3_fl0", 1'b0, 32'h0, 1'b1);
        checkOutput("t3_pc_held", out_pc, 32'h200);
        applyStimulus(1'b1, 32'h20C, 1'b1, 1'b0);
        checkMain("t3_a", 1'b1, 32'h20C, 1'b1);
        applyStimulus(1'b1, 32'h210, 1'b1, 1'b1);
        checkMain("t3_fl1", 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkMain("t3_gone", 1'b0, 32'h0, 1'b1);
        applyStimulus(1'b1, 32'h214, 1'b1, 1'b0);
        checkMain("t3_b", 1'b1, 32'h214, 1'b1);

        // 4: bubble counter saturation on the 4-bit instance
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        end
        checkOutput("t4_sat", 32'(d4_bubble_cnt), 32'd15);
        checkOutput("t4_wide", 32'(bubble_cnt), 32'd20);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("t4_flush_keeps", 32'(d4_bubble_cnt), 32'd15);
        doReset();
        checkOutput("t4_reset_clr", 32'(d4_bubble_cnt), 32'd0);
        checkOutput("t4_reset_clr_wide", 32'(bubble_cnt), 32'd0);

        // 5: async reset between edges in the middle of a stream
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        checkMain("t5_a", 1'b1, 32'h300, 1'b1);
        applyStimulus(1'b1, 32'h304, 1'b1, 1'b0);
        checkMain("t5_b", 1'b1, 32'h304, 1'b1);
        in_pc    = 32'h308;
        in_instr = instrOf(32'h308);
        in_ctrl  = ctrlOf(32'h308);
        #2 reset = 1'b1;
        #1;
        checkMain("t5_rst", 1'b0, 32'h0, 1'b1);
        checkOutput("t5_rst_pc", out_pc, 32'd0);
        #1 reset = 1'b0;
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0);
        checkMain("t5_after", 1'b1, 32'h400, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkMain("t5_drain", 1'b0, 32'h0, 1'b1);

        // 6: random traffic against a 2-deep in-order queue model
        doReset();
        model_q.delete();
        next_pc = 32'h1000;
        for (int i = 0; i < 10000; i++) begin
            rv     = ($urandom_range(0, 3) != 0);
            rr     = ($urandom_range(0, 3) != 0);
            rf     = ($urandom_range(0, 63) == 0);
            m_acc  = rv && (model_q.size() < 2);
            m_emit = rr && (model_q.size() > 0);
            applyStimulus(rv, next_pc, rr, rf);
            if (rf) begin
                model_q.delete();
            end else begin
                if (m_emit) begin
                    void'(model_q.pop_front());
                end
                if (m_acc) begin
                    model_q.push_back(next_pc);
                end
            end
            if (m_acc) begin
                next_pc = next_pc + 32'd4;
            end
            exp_pc = (model_q.size() > 0) ? model_q[0] : 32'h0;
            checkMain("t6", model_q.size() > 0, exp_pc, model_q.size() < 2);
            checkOutput("t6_skid_implies_main", 32'(dut.s_valid & ~dut.m_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
